// File: rtl/fft_frame_sched.sv
// Frame scheduler in front of the 16-lane FFT: ping-pong buffers incoming blocks into
// frames, launches each full frame as one contiguous burst and tracks frames in flight.
module fft_frame_sched #(
    parameter int IN_WIDTH     = 9,
    parameter int NUM          = 16,
    parameter int N            = 512,
    parameter int BLOCKS       = N / NUM,
    parameter int MAX_INFLIGHT = 2,
    parameter int GAP          = 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [NUM*IN_WIDTH-1:0]            s_din_i,
    input  logic [NUM*IN_WIDTH-1:0]            s_din_q,
    output logic                               fft_valid_in,
    output logic [NUM*IN_WIDTH-1:0]            fft_din_i,
    output logic [NUM*IN_WIDTH-1:0]            fft_din_q,
    input  logic                               fft_valid_out,
    output logic                               frame_start,
    output logic                               frame_done,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
    output logic                               err_unexp,
    output logic                               err_gap
);
    localparam int BW = NUM * IN_WIDTH;
    localparam int CW = $clog2(BLOCKS);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, BURST, GAPWAIT} state_t;

    state_t        state, state_nxt;
    logic [1:0]    full;
    logic          wr_bank, rd_bank;
    logic [CW-1:0] wr_cnt, rd_cnt, out_cnt, rd_sel;
    logic [GW-1:0] gap_cnt;
    logic          accept, wr_last, rd_last, gap_done, launch_ok;
    logic          launch, burst_end, present;
    logic          out_hit, out_last;

    // Lanes are packed lane 0 in the LSBs; samples pass through untouched.
    logic [BW-1:0] mem_i [2*BLOCKS];
    logic [BW-1:0] mem_q [2*BLOCKS];

    assign s_ready   = !full[wr_bank];
    assign accept    = s_valid && s_ready;
    assign wr_last   = (wr_cnt == CW'(BLOCKS - 1));
    assign rd_last   = (rd_cnt == CW'(BLOCKS - 1));
    assign gap_done  = (gap_cnt == GW'(GAP - 1));
    assign launch_ok = full[rd_bank] && (inflight < IW'(MAX_INFLIGHT));
    assign out_hit   = fft_valid_out && (inflight != '0);
    assign out_last  = out_hit && (out_cnt == CW'(BLOCKS - 1));

    // Write side: fill the current bank, hand it over once the frame is complete
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_i[{wr_bank, wr_cnt}] <= s_din_i;
            mem_q[{wr_bank, wr_cnt}] <= s_din_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
        end else if (accept) begin
            if (wr_last) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Write only ever targets a non-full bank, so set and clear never hit the same bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= '0;
        end else begin
            if (accept && wr_last) full[wr_bank] <= 1'b1;
            if (burst_end)         full[rd_bank] <= 1'b0;
        end
    end

    // Read FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch_ok) state_nxt = BURST;
            BURST:   if (rd_last)   state_nxt = GAPWAIT;
            GAPWAIT: if (gap_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        launch    = (state == IDLE) && launch_ok;
        burst_end = (state == BURST) && rd_last;
        present   = launch || ((state == BURST) && !rd_last);
        rd_sel    = launch ? '0 : rd_cnt + 1'b1;
    end

    // Registered burst outputs; rd_cnt is the index of the block currently presented
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fft_valid_in <= 1'b0;
            frame_start  <= 1'b0;
            fft_din_i    <= '0;
            fft_din_q    <= '0;
            rd_cnt       <= '0;
            rd_bank      <= 1'b0;
            gap_cnt      <= '0;
        end else begin
            frame_start <= launch;
            if (launch) begin
                fft_valid_in <= 1'b1;
                rd_cnt       <= '0;
            end else if (burst_end) begin
                fft_valid_in <= 1'b0;
                rd_bank      <= ~rd_bank;
            end else if (state == BURST) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (present) begin
                fft_din_i <= mem_i[{rd_bank, rd_sel}];
                fft_din_q <= mem_q[{rd_bank, rd_sel}];
            end
            if (state == GAPWAIT) gap_cnt <= gap_done ? '0 : gap_cnt + 1'b1;
            else                  gap_cnt <= '0;
        end
    end

    // Output tracking: count FFT output blocks per frame, bound frames in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_cnt    <= '0;
            frame_done <= 1'b0;
            inflight   <= '0;
            err_unexp  <= 1'b0;
            err_gap    <= 1'b0;
        end else begin
            frame_done <= out_last;
            if (out_hit) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
            if (fft_valid_out && (inflight == '0)) err_unexp <= 1'b1;
            if (!fft_valid_out && (out_cnt != '0)) err_gap <= 1'b1;
            if (burst_end && !out_last)      inflight <= inflight + 1'b1;
            else if (!burst_end && out_last) inflight <= inflight - 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: scenario table plus hand-written corner sequences, all
// checked every cycle against a frame/burst-level reference model.
module tb_fft_frame_sched;
    localparam int IN_WIDTH = 9;
    localparam int NUM      = 16;
    localparam int N        = 512;
    localparam int BLOCKS   = N / NUM;
    localparam int MAXF     = 2;
    localparam int GAP      = 1;
    localparam int BW       = NUM * IN_WIDTH;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [BW-1:0] s_din_i = '0, s_din_q = '0;
    logic          fft_valid_in;
    logic [BW-1:0] fft_din_i, fft_din_q;
    logic          fft_valid_out;
    logic          frame_start, frame_done, err_unexp, err_gap;
    logic [1:0]    inflight;
    logic          stub_vo = 1'b0, man_vo = 1'b0;

    assign fft_valid_out = stub_vo | man_vo;

    fft_frame_sched #(.IN_WIDTH(IN_WIDTH), .NUM(NUM), .N(N), .BLOCKS(BLOCKS),
                      .MAX_INFLIGHT(MAXF), .GAP(GAP)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_din_i(s_din_i), .s_din_q(s_din_q), .fft_valid_in(fft_valid_in),
        .fft_din_i(fft_din_i), .fft_din_q(fft_din_q), .fft_valid_out(fft_valid_out),
        .frame_start(frame_start), .frame_done(frame_done), .inflight(inflight),
        .err_unexp(err_unexp), .err_gap(err_gap));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_vec(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state: frame/burst bookkeeping derived from the scheduling rules
    int            m_acc, m_bd, m_inf, m_blen, m_idle, m_out;
    bit            m_gap, m_unexp, e_valid, e_start, e_done;
    logic [BW-1:0] exp_i[$], exp_q[$];
    logic [BW-1:0] last_i, last_q;
    int            n_done, n_starts, n_sent;
    longint        cyc = 0;
    longint        due[$];
    bit            fft_en = 1'b0, mon_en = 1'b0;
    int            drop_at = -1;
    bit            st_act = 1'b0, st_drp = 1'b0;
    int            st_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            m_acc = 0; m_bd = 0; m_inf = 0; m_blen = 0; m_idle = GAP + 1; m_out = 0;
            m_gap = 0; m_unexp = 0; e_valid = 0; e_start = 0; e_done = 0;
            exp_i.delete(); exp_q.delete(); last_i = '0; last_q = '0;
        end else if (mon_en) begin
            int stored, inc, dec;
            bit rdy_m, nv, ns, nd;
            stored = m_acc / BLOCKS - m_bd;
            rdy_m  = (stored < 2);
            chk("valid_in", fft_valid_in, e_valid);
            chk("frame_start", frame_start, e_start);
            chk("frame_done", frame_done, e_done);
            chk("inflight", inflight, m_inf);
            chk("s_ready", s_ready, rdy_m);
            chk("err_gap", err_gap, m_gap);
            chk("err_unexp", err_unexp, m_unexp);
            if (frame_start) begin
                n_starts++;
                if (fft_en) due.push_back(cyc + 100);
            end
            if (frame_done) n_done++;
            if (fft_valid_in) begin
                if (exp_i.size() == 0) chk("data_avail", 0, 1);
                else begin
                    chk_vec("din_i", fft_din_i, exp_i.pop_front());
                    chk_vec("din_q", fft_din_q, exp_q.pop_front());
                end
                last_i = fft_din_i; last_q = fft_din_q;
            end else begin
                chk_vec("din_hold_i", fft_din_i, last_i);
                chk_vec("din_hold_q", fft_din_q, last_q);
            end
            inc = 0; dec = 0; nv = 0; ns = 0; nd = 0;
            if (e_valid) begin
                m_blen++;
                if (m_blen == BLOCKS) begin
                    inc = 1; m_idle = 0; m_blen = 0;
                end else nv = 1;
            end else begin
                m_idle++;
                if (stored > 0 && m_inf < MAXF && m_idle >= GAP + 1) begin
                    nv = 1; ns = 1;
                end
            end
            if (s_valid && rdy_m) begin
                exp_i.push_back(s_din_i); exp_q.push_back(s_din_q); m_acc++;
            end
            if (fft_valid_out) begin
                if (m_inf == 0) m_unexp = 1;
                else begin
                    m_out++;
                    if (m_out == BLOCKS) begin m_out = 0; dec = 1; nd = 1; end
                end
            end else if (m_out > 0) m_gap = 1;
            m_bd += inc; m_inf += inc - dec;
            e_valid = nv; e_start = ns; e_done = nd;
        end
    end

    // Stub FFT: 100 cycles after each burst start, return BLOCKS output blocks
    initial begin
        forever begin
            @(posedge clk); #1;
            stub_vo = 1'b0;
            if (!rstn) begin
                due.delete(); st_act = 1'b0;
            end else begin
                if (!st_act && due.size() > 0 && cyc >= due[0]) begin
                    void'(due.pop_front()); st_act = 1'b1; st_idx = 0; st_drp = 1'b0;
                end
                if (st_act) begin
                    if (st_idx == drop_at && !st_drp) st_drp = 1'b1;
                    else begin
                        stub_vo = 1'b1; st_idx++;
                        if (st_idx == BLOCKS) st_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected end earlier", $time);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; s_valid = 1'b0; man_vo = 1'b0; fft_en = 1'b0; drop_at = -1;
        #2;
        chk("rst_valid_in", fft_valid_in, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err_gap", err_gap, 0);
        chk("rst_err_unexp", err_unexp, 0);
        chk_vec("rst_din_i", fft_din_i, '0);
        @(negedge clk); #2;
        rstn = 1'b1; n_done = 0; n_starts = 0; n_sent = 0;
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic send_block(logic [BW-1:0] di, logic [BW-1:0] dq);
        bit r;
        s_valid = 1'b1; s_din_i = di; s_din_q = dq;
        for (int t = 0; ; t++) begin
            @(negedge clk); r = s_ready;
            @(posedge clk); #1;
            if (r) break;
            if (t > 3000) begin chk("send_timeout", 0, 1); break; end
        end
        n_sent++;
        s_valid = 1'b0;
    endtask

    // mode 0: k-pattern back-to-back, 1: every other cycle, 2: random gaps and data
    task automatic send_frames(int nf, int mode);
        logic [BW-1:0] di, dq;
        for (int f = 0; f < nf; f++) begin
            for (int b = 0; b < BLOCKS; b++) begin
                if (mode == 1) begin
                    s_valid = 1'b0; @(posedge clk); #1;
                end else if (mode == 2) begin
                    repeat ($urandom_range(0, 2)) begin
                        s_valid = 1'b0; s_din_i = {5{$urandom}}; @(posedge clk); #1;
                    end
                end
                for (int l = 0; l < NUM; l++) begin
                    int k;
                    k = b * NUM + l;
                    if (mode == 0) begin
                        di[l*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(k % 256);
                        dq[l*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'(-k);
                    end else begin
                        di[l*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom_range(0, 511));
                        dq[l*IN_WIDTH +: IN_WIDTH] = IN_WIDTH'($urandom_range(0, 511));
                    end
                end
                send_block(di, dq);
            end
        end
    endtask

    task automatic man_frame();
        for (int i = 0; i < BLOCKS; i++) begin
            @(posedge clk); #1; man_vo = 1'b1;
        end
        @(posedge clk); #1; man_vo = 1'b0;
    endtask

    task automatic wait_done(string tag, int target, int lim);
        for (int t = 0; t < lim && n_done < target; t++) @(negedge clk);
        chk({tag, "_done"}, n_done, target);
    endtask

    typedef struct {
        string name;
        int    frames;
        int    mode;
        int    drop;
        int    exp_done;
        bit    exp_gap;
    } scen_t;

    scen_t tbl[4];

    initial begin
        tbl[0] = '{"single",    1, 0, -1, 1, 1'b0};
        tbl[1] = '{"throttled", 3, 1, -1, 3, 1'b0};
        tbl[2] = '{"random",    4, 2, -1, 4, 1'b0};
        tbl[3] = '{"drop10",    1, 2, 10, 1, 1'b1};
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_reset();
            fft_en = 1'b1; drop_at = tbl[i].drop;
            send_frames(tbl[i].frames, tbl[i].mode);
            wait_done(tbl[i].name, tbl[i].exp_done, 3000);
            repeat (5) @(negedge clk);
            chk({tbl[i].name, "_starts"}, n_starts, tbl[i].frames);
            chk({tbl[i].name, "_inflight"}, inflight, 0);
            chk({tbl[i].name, "_err_gap"}, err_gap, tbl[i].exp_gap);
            chk({tbl[i].name, "_err_unexp"}, err_unexp, 0);
        end

        // Output pulse with nothing in flight; err_gap from the drop must stay set
        @(posedge clk); #1; man_vo = 1'b1;
        @(posedge clk); #1; man_vo = 1'b0;
        @(negedge clk);
        chk("unexp_set", err_unexp, 1);
        chk("gap_sticky", err_gap, 1);

        // Backpressure with a silent FFT: two bursts, both banks full, fifth frame stalls
        do_reset();
        fork send_frames(5, 0); join_none
        repeat (300) @(negedge clk);
        chk("bp_starts", n_starts, 2);
        chk("bp_inflight", inflight, 2);
        chk("bp_s_ready", s_ready, 0);
        chk("bp_sent", n_sent, 4 * BLOCKS);
        fft_en = 1'b1;
        man_frame();
        for (int t = 0; t < 10 && n_starts < 3; t++) @(negedge clk);
        chk("bp_third_burst", n_starts, 3);
        man_frame();
        for (int t = 0; t < 200 && n_sent < 5 * BLOCKS; t++) @(negedge clk);
        chk("bp_resume", n_sent, 5 * BLOCKS);
        wait_done("bp", 5, 3000);
        repeat (5) @(negedge clk);
        chk("bp_inflight_end", inflight, 0);
        chk("bp_s_ready_end", s_ready, 1);

        // Asynchronous reset in the middle of a burst
        do_reset();
        send_frames(1, 2);
        for (int t = 0; t < 100 && !fft_valid_in; t++) @(negedge clk);
        chk("mid_burst_seen", fft_valid_in, 1);
        repeat (15) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("async_valid_in", fft_valid_in, 0);
        chk("async_inflight", inflight, 0);
        @(negedge clk); #2;
        rstn = 1'b1; n_done = 0; n_starts = 0;
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_inflight", inflight, 0);
        @(posedge clk); #1;
        fft_en = 1'b1;
        send_frames(1, 2);
        wait_done("post_rst", 1, 3000);
        repeat (5) @(negedge clk);
        chk("post_rst_starts", n_starts, 1);
        chk("post_rst_inflight_end", inflight, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
